// File: rtl/rijndael_pkg.sv
// -----------------------------------------------------------------------------
// rijndael_pkg
// Shared definitions for the Rijndael encrypt core and its request arbiter:
//   - arb_state_e : arbiter sequencing states
//   - state_size  : state width in bits for NB 32-bit words
//   - key_size    : key width in bits for NK 32-bit words
//   - num_rounds  : round count NR = max(NB, NK) + 6
// No ports (package).
// -----------------------------------------------------------------------------
package rijndael_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } arb_state_e;

   function automatic int state_size(input int nb);
      return 32 * nb;
   endfunction

   function automatic int key_size(input int nk);
      return 32 * nk;
   endfunction

   function automatic int num_rounds(input int nb, input int nk);
      return ((nb > nk) ? nb : nk) + 6;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one position after
// the pointer and wraps, so the previous winner has the lowest priority.
// Ports:
//   i_req   [N-1:0]   request vector
//   i_ptr   [IDW-1:0] index of the previous winner
//   o_grant [N-1:0]   one-hot grant (zero when no request)
//   o_idx   [IDW-1:0] index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_idx
);

   logic [IDW-1:0] w_cand;
   logic           w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = IDW'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_cand]) begin
            w_found         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/rijndael_encrypt_arbiter.sv
// -----------------------------------------------------------------------------
// rijndael_encrypt_arbiter
// Shares one Rijndael encrypt core between NREQ requesters. Requests are
// picked round-robin, the operands are latched for the whole core operation,
// the core's enable/ready handshake is sequenced, and the ciphertext is
// returned on a single valid/ready response channel tagged with the id.
// Only one operation is ever outstanding.
//
// Optional feature: define RIJNDAEL_ARB_WATCHDOG_EN to abort an operation
// that stays in WAIT_BUSY/WAIT_DONE for TIMEOUT cycles; the abort is reported
// as a response with rsp_error_o=1 and zero ciphertext.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester handshake (ready one-hot)
//   req_plaintext_i / req_key_i    operands, requester i in slice i
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o, rsp_ciphertext_o     response id and data
//   rsp_error_o                    watchdog abort flag (0 without feature)
//   core_enable_o / core_ready_i   core start pulse / core idle
//   core_plaintext_o, core_key_o   latched operands to the core
//   core_ciphertext_i              core result
// -----------------------------------------------------------------------------
module rijndael_encrypt_arbiter
   import rijndael_pkg::*;
#(
   parameter  int NB        = 4,
   parameter  int NK        = 4,
   parameter  int NREQ      = 4,
   parameter  int TIMEOUT   = 64,
   localparam int STATESIZE = state_size(NB),
   localparam int KEYSIZE   = key_size(NK),
   localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NREQ-1:0]           req_valid_i,
   output logic [NREQ-1:0]           req_ready_o,
   input  logic [NREQ*STATESIZE-1:0] req_plaintext_i,
   input  logic [NREQ*KEYSIZE-1:0]   req_key_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [IDW-1:0]            rsp_id_o,
   output logic [STATESIZE-1:0]      rsp_ciphertext_o,
   output logic                      rsp_error_o,
   output logic                      core_enable_o,
   input  logic                      core_ready_i,
   output logic [STATESIZE-1:0]      core_plaintext_o,
   output logic [KEYSIZE-1:0]        core_key_o,
   input  logic [STATESIZE-1:0]      core_ciphertext_i
);

   arb_state_e           r_state;
   logic [IDW-1:0]       r_ptr;
   logic [IDW-1:0]       r_id;
   logic                 r_enable;
   logic                 r_rsp_valid;
   logic [STATESIZE-1:0] r_pt;
   logic [STATESIZE-1:0] r_ct;
   logic [KEYSIZE-1:0]   r_key;

   logic [NREQ-1:0]      w_grant;
   logic [IDW-1:0]       w_idx;
   logic                 w_accept;

   rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_rr_arbiter (
      .i_req   (req_valid_i),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // Gated by rst_ni so that no ready pulse escapes while reset is held.
   assign w_accept    = rst_ni & (r_state == IDLE) & core_ready_i & (|req_valid_i);
   assign req_ready_o = w_accept ? w_grant : '0;

`ifdef RIJNDAEL_ARB_WATCHDOG_EN
   localparam int CNTW = $clog2(TIMEOUT + 1);
   logic [CNTW-1:0] r_cnt;
   logic            r_err;
   logic            w_timeout;

   assign w_timeout   = (r_cnt == CNTW'(TIMEOUT));
   assign rsp_error_o = r_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT > 0);
   assign rsp_error_o      = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_ptr       <= IDW'(NREQ - 1);
         r_id        <= '0;
         r_enable    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_pt        <= '0;
         r_key       <= '0;
         r_ct        <= '0;
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
         r_cnt       <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pt     <= req_plaintext_i[w_idx*STATESIZE +: STATESIZE];
                  r_key    <= req_key_i[w_idx*KEYSIZE +: KEYSIZE];
                  r_id     <= w_idx;
                  r_ptr    <= w_idx;
                  r_enable <= 1'b1;
                  r_state  <= START;
               end
            end
            START: begin
               r_enable <= 1'b0;
               r_state  <= WAIT_BUSY;
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
               r_cnt    <= '0;
`endif
            end
            WAIT_BUSY: begin
               if (!core_ready_i) begin
                  r_state <= WAIT_DONE;
               end
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
               // Abort overrides the busy edge: the core has not finished.
               r_cnt <= r_cnt + 1'b1;
               if (w_timeout) begin
                  r_ct        <= '0;
                  r_err       <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
`endif
            end
            WAIT_DONE: begin
               if (core_ready_i) begin
                  r_ct        <= core_ciphertext_i;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
               // A genuine completion in the timeout cycle still wins.
               else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_timeout) begin
                     r_ct        <= '0;
                     r_err       <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= RESP;
                  end
               end
`endif
            end
            RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
                  r_err       <= 1'b0;
`endif
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign core_enable_o    = r_enable;
   assign core_plaintext_o = r_pt;
   assign core_key_o       = r_key;
   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_id_o         = r_id;
   assign rsp_ciphertext_o = r_ct;

endmodule

// File: tb/tb_rijndael_encrypt_arbiter.sv
module tb_rijndael_encrypt_arbiter;

   localparam int NREQ = 4;
   localparam int SS   = 128;
   localparam int KS   = 128;
   localparam int IDW  = 2;
   localparam int TMO  = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*SS-1:0]   req_pt = '0;
   logic [NREQ*KS-1:0]   req_key = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [IDW-1:0]       rsp_id;
   logic [SS-1:0]        rsp_ct;
   logic                 rsp_err;
   logic                 core_en;
   logic                 core_ready;
   logic [SS-1:0]        core_pt;
   logic [KS-1:0]        core_key;
   logic [SS-1:0]        core_ct;

   always #5 clk = ~clk;

   rijndael_encrypt_arbiter #(
      .NB(4), .NK(4), .NREQ(NREQ), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_plaintext_i(req_pt), .req_key_i(req_key),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_ciphertext_o(rsp_ct), .rsp_error_o(rsp_err),
      .core_enable_o(core_en), .core_ready_i(core_ready),
      .core_plaintext_o(core_pt), .core_key_o(core_key),
      .core_ciphertext_i(core_ct)
   );

   // ---------------- AES-128 reference (FIPS-197) ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, x;
      for (int b = 0; b < 256; b++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (b != 0 && gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
         x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_t[b] = x;
      end
   endtask

   function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s[16], k[16], t[16], tmp[4], rc;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         s[i] = pt[127-8*i -: 8];
         k[i] = key[127-8*i -: 8];
         s[i] ^= k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i + 4*(i%4)) % 16]];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
               s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
            end else begin
               for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
            end
         end
         tmp[0] = sbox_t[k[13]] ^ rc;
         tmp[1] = sbox_t[k[14]];
         tmp[2] = sbox_t[k[15]];
         tmp[3] = sbox_t[k[12]];
         for (int i = 0; i < 4; i++) k[i] ^= tmp[i];
         for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
         rc = xt(rc);
         for (int i = 0; i < 16; i++) s[i] ^= k[i];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- core model ----------------
   int core_delay = 11;
   bit core_stuck = 1'b0;
   int core_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_ready <= 1'b1;
         core_cnt   <= 0;
         core_ct    <= '0;
      end else if (core_cnt > 0) begin
         if (core_cnt == 1) begin
            core_ready <= 1'b1;
            core_ct    <= aes128(core_pt, core_key);
         end
         core_cnt <= core_cnt - 1;
      end else if (core_en && core_ready) begin
         core_ready <= 1'b0;
         core_cnt   <= core_stuck ? 1000000 : core_delay;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [IDW-1:0] id;
      logic [SS-1:0]  ct;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0;
   int   outstanding = 0;
   int   m_ptr = NREQ - 1;
   int   n_grant = 0, n_enable = 0, n_resp = 0;
   int   mw;
   exp_t me;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Round-robin rule: first valid requester after the last winner, wrapping.
   function automatic int model_winner(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         outstanding = 0;
         m_ptr = NREQ - 1;
      end else begin
         if (core_en) n_enable++;
         if (req_ready != '0) begin
            mw = model_winner(req_valid, m_ptr);
            if (mw < 0) begin
               n_cmp++; n_bad++;
               $display("FAIL grant_no_req: ready %b with valid %b", req_ready, req_valid);
            end else begin
               check("grant_vec", 128'(req_ready), 128'(1) << mw);
               check("grant_single_outstanding", 128'(outstanding), 128'd0);
               m_ptr = mw;
               outstanding++;
               n_grant++;
               grant_log.push_back(mw);
               me.id  = IDW'(mw);
               me.err = 1'b0;
               me.ct  = aes128(req_pt[mw*SS +: SS], req_key[mw*KS +: KS]);
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
               if (core_stuck) begin
                  me.ct  = '0;
                  me.err = 1'b1;
               end
`endif
               exp_q.push_back(me);
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp_unexpected: id %0d ct %h with nothing pending", rsp_id, rsp_ct);
            end else begin
               check("rsp_id", 128'(rsp_id), 128'(exp_q[0].id));
               check("rsp_ct", rsp_ct, exp_q[0].ct);
               check("rsp_err", 128'(rsp_err), 128'(exp_q[0].err));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  outstanding--;
                  n_resp++;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_grant(input string name, output int t);
      t = -1;
      for (int i = 0; i < 200 && t < 0; i++) begin
         @(negedge clk);
         if (req_ready != '0) t = cyc;
      end
      if (t < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no grant within 200 cycles", name);
      end
   endtask

   task automatic wait_rsp(input string name, output int t);
      t = -1;
      for (int i = 0; i < 200 && t < 0; i++) begin
         @(negedge clk);
         if (rsp_valid) t = cyc;
      end
      if (t < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no response within 200 cycles", name);
      end
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (outstanding == 0 && !rsp_valid && core_ready) done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: still busy after 500 cycles (outstanding %0d)", name, outstanding);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 128'(req_ready), 128'd0);
      check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
      check({tag, "_rsp_id"}, 128'(rsp_id), 128'd0);
      check({tag, "_rsp_ct"}, rsp_ct, 128'd0);
      check({tag, "_rsp_err"}, 128'(rsp_err), 128'd0);
      check({tag, "_core_en"}, 128'(core_en), 128'd0);
      check({tag, "_core_pt"}, core_pt, 128'd0);
      check({tag, "_core_key"}, core_key, 128'd0);
   endtask

   // ---------------- main sequence ----------------
   int t_g, t_r, t_hs, e0, g0, vcount;
   logic [127:0] held_pt;

   initial begin
      build_sbox();
      for (int i = 0; i < NREQ; i++) begin
         req_pt[i*SS +: SS]  = rnd128();
         req_key[i*KS +: KS] = rnd128();
      end
      req_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");

      // All four requesters valid from reset: order 0,1,2,3,0.
      core_delay = 3;
      rst_n = 1'b1;
      for (int i = 0; i < 400 && n_grant < 5; i++) @(negedge clk);
      @(posedge clk) #1 req_valid = '0;
      wait_idle("simul_drain");
      check("simul_grants", 128'(grant_log.size()), 128'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         check("simul_order", 128'(grant_log[i]), 128'(i % NREQ));
      check("simul_enables", 128'(n_enable), 128'd5);

      // Single request, FIPS-197 vector, core busy for 11 cycles.
      core_delay = 11;
      @(posedge clk) #1;
      req_pt[2*SS +: SS]  = 128'h00112233445566778899aabbccddeeff;
      req_key[2*KS +: KS] = 128'h000102030405060708090a0b0c0d0e0f;
      req_valid = 4'b0100;
      wait_grant("fips_grant", t_g);
      check("fips_ready", 128'(req_ready), 128'h4);
      @(posedge clk) #1 req_valid = '0;
      @(negedge clk) check("fips_ready_pulse", 128'(req_ready), 128'd0);
      wait_rsp("fips_rsp", t_r);
      check("fips_latency", 128'(t_r - t_g), 128'd14);
      check("fips_id", 128'(rsp_id), 128'd2);
      check("fips_ct", rsp_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      wait_idle("fips_drain");

      // Backpressure with requester 1 pending.
      core_delay = 2;
      @(posedge clk) #1;
      rsp_ready = 1'b0;
      req_pt[0 +: SS] = rnd128();
      req_valid = 4'b0001;
      wait_grant("bp_grant0", t_g);
      @(posedge clk) #1;
      req_pt[SS +: SS] = rnd128();
      req_valid = 4'b0010;
      wait_rsp("bp_rsp0", t_r);
      e0 = n_enable;
      g0 = n_grant;
      vcount = 0;
      repeat (20) @(negedge clk) if (rsp_valid) vcount++;
      check("bp_valid_held", 128'(vcount), 128'd20);
      check("bp_no_grant", 128'(n_grant), 128'(g0));
      check("bp_no_enable", 128'(n_enable), 128'(e0));
      @(posedge clk) #1 rsp_ready = 1'b1;
      @(negedge clk) t_hs = cyc;
      wait_grant("bp_grant1", t_g);
      check("bp_grant1_vec", 128'(req_ready), 128'h2);
      check("bp_grant1_gap", 128'(t_g - t_hs), 128'd1);
      @(posedge clk) #1 req_valid = '0;
      wait_idle("bp_drain");

      // Operand stability: plaintext slice changes while the core is busy.
      core_delay = 10;
      @(posedge clk) #1;
      held_pt = rnd128();
      req_pt[3*SS +: SS] = held_pt;
      req_valid = 4'b1000;
      wait_grant("stab_grant", t_g);
      @(posedge clk) #1 req_valid = '0;
      repeat (5) @(posedge clk);
      #1 req_pt[3*SS +: SS] = ~held_pt;
      @(negedge clk) check("stab_core_pt", core_pt, held_pt);
      wait_idle("stab_drain");

      // Reset in WAIT_DONE: outputs clear asynchronously, requester 0 first.
      @(posedge clk) #1;
      req_pt[2*SS +: SS] = rnd128();
      req_valid = 4'b0100;
      wait_grant("rst_grant", t_g);
      @(posedge clk) #1 req_valid = '0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      req_valid = 4'b1001;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_grant("rst_first", t_g);
      check("rst_first_vec", 128'(req_ready), 128'h1);
      @(posedge clk) #1 req_valid = 4'b1000;
      wait_grant("rst_second", t_g);
      check("rst_second_vec", 128'(req_ready), 128'h8);
      @(posedge clk) #1 req_valid = '0;
      wait_idle("rst_drain");

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk) #1;
         core_delay = $urandom_range(1, 6);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) req_valid[i] = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) begin
               req_pt[i*SS +: SS]  = rnd128();
               req_key[i*KS +: KS] = rnd128();
            end
         end
      end
      @(posedge clk) #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("rand_drain");
      check("rand_all_answered", 128'(n_resp), 128'(n_grant - 1));

      // Core that never finishes.
      @(posedge clk) #1;
      core_stuck = 1'b1;
      req_valid = 4'b0010;
      wait_grant("wd_grant", t_g);
      @(posedge clk) #1 req_valid = '0;
`ifdef RIJNDAEL_ARB_WATCHDOG_EN
      wait_rsp("wd_rsp", t_r);
      check("wd_latency", 128'(t_r - t_g), 128'(TMO + 3));
      check("wd_err", 128'(rsp_err), 128'd1);
      check("wd_ct", rsp_ct, 128'd0);
`else
      vcount = 0;
      repeat (150) @(negedge clk) if (rsp_valid) vcount++;
      check("wd_off_no_rsp", 128'(vcount), 128'd0);
`endif
      @(posedge clk) #1 rst_n = 1'b0;
      core_stuck = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
